transport_packetizer: RTL and testbench
=======================================

// Module: transport_packetizer
// PURPOSE
//  Parametrised multi-channel successor to the single-stream transport sender.
//  Buffers voice samples per channel, frames them into byte-serial packets (header, length,
//  payload, XOR checksum) and interleaves single-shot command packets.
//  Sits between the audio/codec path and the byte-wide link layer; the link layer throttles
//  it with out_ready.
// PARAMETERS
//  DATA_W          16  sample width in bits; multiple of 8, 8..64
//  CHAN_W          1   channel index width; CHANNELS = 2**CHAN_W, CHAN_W <= 6
//  FIFO_DEPTH      8   samples per channel FIFO; power of 2, >= SAMPLES_PER_PKT
//  SAMPLES_PER_PKT 2   samples per data packet; SAMPLES_PER_PKT*DATA_W/8 <= 255
// PORTS
//  clk        in   1         system clock, all logic rising-edge
//  reset      in   1         asynchronous, active-high; clears all state
//  cmd        in   2         command code 01/10/11; sampled only when cmd_valid=1
//  cmd_valid  in   1         one-cycle command request; accepted iff cmd_ready=1
//  cmd_chan   in   CHAN_W    channel the command refers to
//  cmd_ready  out  1         command slot empty
//  data       in   DATA_W    sample to enqueue
//  data_chan  in   CHAN_W    destination channel FIFO for data
//  sendData   in   1         push data into FIFO[data_chan] this cycle
//  out_ready  in   1         link accepts packetOut this cycle
//  sending    out  1         packetOut valid
//  packetOut  out  8         packet byte
//  busy       out  1         packet in progress (state != IDLE)
//  overflow   out  CHANNELS  sticky per-channel sample-drop flag
// BEHAVIOUR
//  Reset: sending=0, packetOut=0, busy=0, cmd_ready=1, overflow=0.
//   FIFOs emptied, command slot emptied, RR pointer=0, state=IDLE.
//   Reset mid-packet aborts it; no residual bytes after release.
//  Packet bytes:
//   HDR     {type[1:0], chan zero-extended to 6b}; type 00=data, else cmd code
//   LEN     payload byte count (0 for commands)
//   PAYLOAD samples oldest first, each MSB byte first
//   CSUM    XOR of all preceding bytes of the packet
//  Byte handshake: byte transfers on a cycle with sending=1 and out_ready=1.
//   With out_ready=0, packetOut and state hold unchanged.
//  FSM: IDLE -> HDR -> LEN -> (PAYLOAD)* -> CSUM -> IDLE.
//   Each transition fires on transfer; commands skip PAYLOAD.
//  IDLE selection, evaluated every IDLE cycle:
//   - pending command has priority over data
//   - otherwise the first channel with count >= SAMPLES_PER_PKT, searched from RR pointer upward
//   - RR pointer <= chosen channel + 1 (mod CHANNELS)
//   - nothing eligible: stay in IDLE
//  Latency: first HDR sending=1 one cycle after the selecting IDLE cycle.
//   IDLE lasts >= 1 cycle, so back-to-back packets have exactly one sending=0 gap cycle.
//  Command slot: one entry; cmd_valid with cmd_ready=1 loads it and cmd_ready drops next cycle.
//   Freed (cmd_ready=1) the cycle after the command's CSUM transfers.
//   cmd_valid with cmd_ready=0 is ignored; cmd=00 with cmd_valid is ignored.
//  FIFOs:
//   - push when sendData=1; one push per cycle
//   - pop when the last byte of a sample transfers
//   - push to a full FIFO drops the sample and sets overflow[ch] (sticky until reset)
//   - push and pop on the same full FIFO in the same cycle: push accepted, no overflow
//   - pointers wrap modulo FIFO_DEPTH; count is CHAN-independent, 0..FIFO_DEPTH
//   - pushes to a channel mid-transmission are allowed
//  busy=1 from the HDR cycle through the CSUM transfer cycle.
// TESTING (defaults: DATA_W=16, CHAN_W=1, FIFO_DEPTH=8, SAMPLES_PER_PKT=2)
//  T1 cmd_valid=1,cmd=01,cmd_chan=0, out_ready=1 -> bytes 40,00,40; cmd_ready low until after CSUM
//  T2 push 8000,8001 on ch1 -> 01,04,80,00,80,01,04; busy high for exactly 7 cycles
//  T3 both channels reach 2 samples in one cycle -> ch0 packet, one idle cycle, then ch1 packet
//  T4 cmd 10 on ch1 loaded while ch0 holds 2 samples -> 81,00,81 sent before ch0 data packet
//  T5 out_ready=0, push 9 samples ch0 -> overflow[0]=1; released: samples 1..8 out in order, none lost
//  T6 assert reset during 2nd payload byte with out_ready toggling -> outputs 0 immediately;
//     after release sending stays 0 until new samples arrive

Source files
------------

// File: rtl/transport_packetizer_if.sv
// Command, sample and byte-link signals of the transport packetizer.
// The master side feeds commands/samples and throttles the link; the slave side is the packetizer.
interface transport_packetizer_if #(
  parameter int DATA_W = 16,
  parameter int CHAN_W = 1
);
  localparam int CHANNELS = 2 ** CHAN_W;

  logic [1:0]          cmd;
  logic                cmd_valid;
  logic [CHAN_W-1:0]   cmd_chan;
  logic                cmd_ready;
  logic [DATA_W-1:0]   data;
  logic [CHAN_W-1:0]   data_chan;
  logic                sendData;
  logic                out_ready;
  logic                sending;
  logic [7:0]          packetOut;
  logic                busy;
  logic [CHANNELS-1:0] overflow;

  modport master (
    output cmd, cmd_valid, cmd_chan, data, data_chan, sendData, out_ready,
    input  cmd_ready, sending, packetOut, busy, overflow
  );

  modport slave (
    input  cmd, cmd_valid, cmd_chan, data, data_chan, sendData, out_ready,
    output cmd_ready, sending, packetOut, busy, overflow
  );
endinterface

// File: rtl/transport_packetizer.sv
// Multi-channel sample packetizer: per-channel FIFOs, a one-entry command slot and a
// byte-serial framer emitting HDR, LEN, PAYLOAD, CSUM under out_ready flow control.
module transport_packetizer #(
  parameter int DATA_W          = 16,
  parameter int CHAN_W          = 1,
  parameter int FIFO_DEPTH      = 8,
  parameter int SAMPLES_PER_PKT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  transport_packetizer_if.slave bus
);
  localparam int CHANNELS = 2 ** CHAN_W;
  localparam int BYTES    = DATA_W / 8;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int BW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0] DATA_LEN = 8'(SAMPLES_PER_PKT * BYTES);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t              state, state_next;

  logic                cmd_pend;
  logic [1:0]          cmd_code;
  logic [CHAN_W-1:0]   cmd_chan_q;

  logic [1:0]          pkt_type;
  logic [CHAN_W-1:0]   pkt_chan;
  logic [7:0]          pkt_len;
  logic [BW-1:0]       byte_idx;
  logic [7:0]          samp_left;
  logic [7:0]          csum;
  logic [CHAN_W-1:0]   rr;

  logic [DATA_W-1:0]   mem [CHANNELS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr [CHANNELS];
  logic [AW-1:0]       rd_ptr [CHANNELS];
  logic [CW-1:0]       count [CHANNELS];
  logic [CHANNELS-1:0] overflow_q;

  logic [CHANNELS-1:0] push_req, pop_ch, push_ok, full;
  logic                xfer, last_byte, pop;
  logic [DATA_W-1:0]   head;
  logic [7:0]          hdr_byte, pay_byte, out_byte;
  logic                sel_found;
  logic [CHAN_W-1:0]   sel_chan, cand;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head      = mem[pkt_chan][rd_ptr[pkt_chan]];
  assign pay_byte  = 8'(head >> (8 * (BYTES - 1 - int'(byte_idx))));
  assign hdr_byte  = {pkt_type, 6'(pkt_chan)};
  assign last_byte = (byte_idx == BW'(BYTES - 1));
  assign xfer      = (state != S_IDLE) && bus.out_ready;
  assign pop       = xfer && (state == S_PAYLOAD) && last_byte;

  // Round-robin search for the first channel holding a full packet's worth of samples.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = rr;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = rr + CHAN_W'(i);
      if (!sel_found && (count[cand] >= CW'(SAMPLES_PER_PKT))) begin
        sel_found = 1'b1;
        sel_chan  = cand;
      end
    end
  end

  always_comb begin
    push_req = '0;
    pop_ch   = '0;
    push_ok  = '0;
    full     = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      push_req[ch] = bus.sendData && (bus.data_chan == CHAN_W'(ch));
      pop_ch[ch]   = pop && (pkt_chan == CHAN_W'(ch));
      full[ch]     = (count[ch] == CW'(FIFO_DEPTH));
      push_ok[ch]  = push_req[ch] && (!full[ch] || pop_ch[ch]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: every register is updated with <= so all flops sample pre-edge values together.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    out_byte   = '0;
    case (state)
      S_IDLE: begin
        if (cmd_pend || sel_found) state_next = S_HDR;
      end
      S_HDR: begin
        out_byte = hdr_byte;
        if (bus.out_ready) state_next = S_LEN;
      end
      S_LEN: begin
        out_byte = pkt_len;
        if (bus.out_ready) state_next = (pkt_len == 8'd0) ? S_CSUM : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        out_byte = pay_byte;
        if (bus.out_ready && last_byte && (samp_left == 8'd1)) state_next = S_CSUM;
      end
      S_CSUM: begin
        out_byte = csum;
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Packet context is latched in IDLE and walked forward one byte per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_type  <= '0;
      pkt_chan  <= '0;
      pkt_len   <= '0;
      byte_idx  <= '0;
      samp_left <= '0;
      csum      <= '0;
      rr        <= '0;
    end else if (state == S_IDLE) begin
      byte_idx  <= '0;
      samp_left <= 8'(SAMPLES_PER_PKT);
      csum      <= '0;
      if (cmd_pend) begin
        pkt_type <= cmd_code;
        pkt_chan <= cmd_chan_q;
        pkt_len  <= 8'd0;
      end else if (sel_found) begin
        pkt_type <= 2'b00;
        pkt_chan <= sel_chan;
        pkt_len  <= DATA_LEN;
        rr       <= sel_chan + 1'b1;
      end
    end else if (xfer) begin
      csum <= csum ^ out_byte;
      if (state == S_PAYLOAD) begin
        if (last_byte) begin
          byte_idx  <= '0;
          samp_left <= samp_left - 8'd1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // The slot stays occupied until its own CSUM leaves, so a queued command cannot be overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_pend   <= 1'b0;
      cmd_code   <= '0;
      cmd_chan_q <= '0;
    end else if (xfer && (state == S_CSUM) && (pkt_type != 2'b00)) begin
      cmd_pend <= 1'b0;
    end else if (bus.cmd_valid && !cmd_pend && (bus.cmd != 2'b00)) begin
      cmd_pend   <= 1'b1;
      cmd_code   <= bus.cmd;
      cmd_chan_q <= bus.cmd_chan;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        count[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (push_ok[ch]) wr_ptr[ch] <= ptr_inc(wr_ptr[ch]);
        if (pop_ch[ch])  rd_ptr[ch] <= ptr_inc(rd_ptr[ch]);
        case ({push_ok[ch], pop_ch[ch]})
          2'b10:   count[ch] <= count[ch] + 1'b1;
          2'b01:   count[ch] <= count[ch] - 1'b1;
          default: ;
        endcase
        if (push_req[ch] && full[ch] && !pop_ch[ch]) overflow_q[ch] <= 1'b1;
      end
    end
  end

  // NOTE: sample storage has no reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok[bus.data_chan]) mem[bus.data_chan][wr_ptr[bus.data_chan]] <= bus.data;
  end

  assign bus.cmd_ready = ~cmd_pend;
  assign bus.sending   = (state != S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.packetOut = out_byte;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_transport_packetizer.sv
// Directed bench for transport_packetizer: a table of single-packet vectors plus
// hand-written sequences for ordering, back-pressure, overflow and mid-packet reset.
module tb_transport_packetizer;
  localparam int DATA_W     = 16;
  localparam int CHAN_W     = 1;
  localparam int FIFO_DEPTH = 8;
  localparam int SPP        = 2;
  localparam int NVEC       = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  transport_packetizer_if #(.DATA_W(DATA_W), .CHAN_W(CHAN_W)) bus ();

  transport_packetizer #(
    .DATA_W(DATA_W), .CHAN_W(CHAN_W), .FIFO_DEPTH(FIFO_DEPTH), .SAMPLES_PER_PKT(SPP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit                is_cmd;
    logic [1:0]        code;
    logic [CHAN_W-1:0] chan;
    logic [15:0]       s0;
    logic [15:0]       s1;
    int                nbytes;
    logic [0:6][7:0]   exp;
  } vec_t;

  vec_t       vecs [NVEC];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         busy_cnt = 0;
  int         rx_base = 0;
  int         bc_base = 0;
  logic [7:0] rx_q [$];
  int         rx_cyc [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc++;

  // Byte monitor: a byte is taken when sending and out_ready are both high mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.sending && bus.out_ready) begin
      rx_q.push_back(bus.packetOut);
      rx_cyc.push_back(cyc);
    end
    if (!reset && bus.busy) busy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " sending"},   32'(bus.sending),   32'd0);
    check({name, " packetOut"}, 32'(bus.packetOut), 32'd0);
    check({name, " busy"},      32'(bus.busy),      32'd0);
    check({name, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({name, " overflow"},  32'(bus.overflow),  32'd0);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.cmd       = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_chan  = '0;
    bus.data      = '0;
    bus.data_chan = '0;
    bus.sendData  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    rx_base = rx_q.size();
    bc_base = busy_cnt;
  endtask

  task automatic push(input logic [CHAN_W-1:0] ch, input logic [DATA_W-1:0] d);
    bus.sendData  = 1'b1;
    bus.data_chan = ch;
    bus.data      = d;
    tick();
    bus.sendData  = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] code, input logic [CHAN_W-1:0] ch);
    bus.cmd_valid = 1'b1;
    bus.cmd       = code;
    bus.cmd_chan  = ch;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Reference model for one data packet appended to the expected byte stream.
  task automatic add_pkt(input logic [CHAN_W-1:0] ch, input logic [15:0] s0, input logic [15:0] s1);
    logic [7:0] b [6];
    logic [7:0] x;
    b = '{{2'b00, 6'(ch)}, 8'd4, s0[15:8], s0[7:0], s1[15:8], s1[7:0]};
    x = 8'h00;
    foreach (b[i]) begin
      exp_q.push_back(b[i]);
      x ^= b[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic expect_stream(input string name, input int budget);
    int n;
    int k;
    logic [7:0] act;
    n = exp_q.size();
    k = 0;
    while ((rx_q.size() < rx_base + n) && (k < budget)) begin
      tick();
      k++;
    end
    check({name, " count"}, 32'(rx_q.size() - rx_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      act = (rx_base + i < rx_q.size()) ? rx_q[rx_base + i] : 8'hxx;
      check($sformatf("%s byte%0d", name, i), 32'(act), 32'(exp_q[i]));
    end
    rx_base += n;
    exp_q.delete();
  endtask

  initial begin
    int c0;
    int first;
    int k;

    vecs[0] = '{1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 3, {8'h40, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{1'b1, 2'b10, 1'b1, 16'h0000, 16'h0000, 3, {8'h81, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{1'b1, 2'b11, 1'b1, 16'h0000, 16'h0000, 3, {8'hC1, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 16'h8000, 16'h8001, 7, {8'h01, 8'h04, 8'h80, 8'h00, 8'h80, 8'h01, 8'h04}};
    vecs[4] = '{1'b0, 2'b00, 1'b0, 16'h1234, 16'hABCD, 7, {8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h44}};
    vecs[5] = '{1'b0, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 7, {8'h00, 8'h04, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h05}};
    vecs[6] = '{1'b1, 2'b01, 1'b1, 16'h0000, 16'h0000, 3, {8'h41, 8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00}};

    // Single packets with out_ready held high: bytes, HDR latency, busy length, nothing extra.
    for (int v = 0; v < NVEC; v++) begin
      do_reset();
      if (vecs[v].is_cmd) begin
        send_cmd(vecs[v].code, vecs[v].chan);
      end else begin
        push(vecs[v].chan, vecs[v].s0);
        push(vecs[v].chan, vecs[v].s1);
      end
      c0 = cyc;
      first = rx_base;
      for (int i = 0; i < vecs[v].nbytes; i++) exp_q.push_back(vecs[v].exp[i]);
      expect_stream($sformatf("v%0d", v), 40);
      check($sformatf("v%0d hdr latency", v),
            (first < rx_cyc.size()) ? 32'(rx_cyc[first]) : 32'hFFFF_FFFF, 32'(c0 + 1));
      repeat (6) tick();
      check($sformatf("v%0d busy cycles", v), 32'(busy_cnt - bc_base), 32'(vecs[v].nbytes));
      check($sformatf("v%0d no extra bytes", v), 32'(rx_q.size() - rx_base), 32'd0);
    end

    // Command slot: held until after CSUM, ignores requests while full and code 00.
    do_reset();
    send_cmd(2'b01, 1'b0);
    check("t1 cmd_ready low after load", 32'(bus.cmd_ready), 32'd0);
    send_cmd(2'b11, 1'b1);
    k = 0;
    while ((rx_q.size() < rx_base + 3) && (k < 30)) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t1 csum reached", 32'(rx_q.size() - rx_base), 32'd3);
    check("t1 cmd_ready low during csum", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("t1 cmd_ready after csum", 32'(bus.cmd_ready), 32'd1);
    repeat (6) tick();
    check("t1 busy cmd ignored", 32'(rx_q.size() - rx_base), 32'd3);
    send_cmd(2'b00, 1'b1);
    repeat (6) tick();
    check("t1 code 00 ignored", 32'(rx_q.size() - rx_base), 32'd3);

    // Both channels eligible together: ch0 then ch1, each after a single gap cycle.
    do_reset();
    bus.out_ready = 1'b0;
    send_cmd(2'b01, 1'b0);
    push(1'b0, 16'h1111);
    push(1'b0, 16'h2222);
    push(1'b1, 16'h3333);
    push(1'b1, 16'h4444);
    bus.out_ready = 1'b1;
    first = rx_base;
    exp_q = '{8'h40, 8'h00, 8'h40};
    add_pkt(1'b0, 16'h1111, 16'h2222);
    add_pkt(1'b1, 16'h3333, 16'h4444);
    expect_stream("t3", 60);
    if (rx_cyc.size() >= first + 17) begin
      check("t3 gap cmd-ch0", 32'(rx_cyc[first + 3] - rx_cyc[first + 2]), 32'd2);
      check("t3 gap ch0-ch1", 32'(rx_cyc[first + 10] - rx_cyc[first + 9]), 32'd2);
    end else begin
      check("t3 gap stream short", 32'(rx_cyc.size()), 32'(first + 17));
    end

    // Command loaded in the same cycle ch0 becomes eligible goes first.
    do_reset();
    push(1'b0, 16'h0102);
    bus.sendData  = 1'b1;
    bus.data_chan = 1'b0;
    bus.data      = 16'h0304;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b10;
    bus.cmd_chan  = 1'b1;
    tick();
    bus.sendData  = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q = '{8'h81, 8'h00, 8'h81, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    expect_stream("t4", 40);

    // Ninth push into a full, stalled FIFO is dropped and flagged; eight samples survive in order.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(1'b0, 16'(16'h1000 + i));
    check("t5 full no overflow", 32'(bus.overflow), 32'd0);
    push(1'b0, 16'h1009);
    check("t5 overflow set", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i += 2) add_pkt(1'b0, 16'(16'h1000 + i), 16'(16'h1001 + i));
    expect_stream("t5", 80);
    repeat (10) tick();
    check("t5 dropped sample absent", 32'(rx_q.size() - rx_base), 32'd0);
    check("t5 overflow sticky", 32'(bus.overflow), 32'd1);

    // Push into a full FIFO in the very cycle a sample pops: accepted without overflow.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(1'b0, 16'(16'h2000 + i));
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    push(1'b0, 16'h2009);
    check("t5b push+pop no overflow", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 8; i += 2) add_pkt(1'b0, 16'(16'h2000 + i), 16'(16'h2001 + i));
    expect_stream("t5b", 80);
    push(1'b0, 16'h200A);
    add_pkt(1'b0, 16'h2009, 16'h200A);
    expect_stream("t5b tail", 40);

    // Reset during the second payload byte while out_ready toggles.
    do_reset();
    push(1'b0, 16'hA1B2);
    push(1'b0, 16'hC3D4);
    k = 0;
    while ((rx_q.size() < rx_base + 3) && (k < 40)) begin
      bus.out_ready = ~bus.out_ready;
      tick();
      k++;
    end
    check("t6 reached payload", 32'(rx_q.size() - rx_base), 32'd3);
    check("t6 second payload byte", 32'(bus.packetOut), 32'hB2);
    bus.out_ready = ~bus.out_ready;
    reset = 1'b1;
    #1;
    check_idle_outputs("t6 async reset");
    tick();
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    rx_base = rx_q.size();
    repeat (20) tick();
    check("t6 no residual bytes", 32'(rx_q.size() - rx_base), 32'd0);
    check("t6 sending stays low", 32'(bus.sending), 32'd0);
    push(1'b0, 16'h5566);
    push(1'b0, 16'h7788);
    add_pkt(1'b0, 16'h5566, 16'h7788);
    expect_stream("t6 fresh", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
